// File: rtl/matrix_line_sched.sv
// Line-buffer scheduler for a 3x3 window stage.
// Sequences two external row-delay FIFOs (FIFO0 holds row r-1, FIFO1 holds
// row r-2) from a raster pixel stream and emits three column-aligned taps
// with the row/column coordinates of the newest pixel. Between frames the
// line FIFOs are cleared through line_rst.
module matrix_line_sched #(
    parameter int c_DATA_WIDTH = 8,
    parameter int c_IMG_WIDTH  = 640,
    parameter int c_IMG_HEIGHT = 480,
    parameter int c_COL_WIDTH  = 10,
    parameter int c_ROW_WIDTH  = 9
) (
    input  logic                    clk,
    input  logic                    rst,
    // pixel source
    input  logic                    pix_sof,
    input  logic                    pix_valid,
    input  logic [c_DATA_WIDTH-1:0] pix_data,
    output logic                    pix_ready,
    // line FIFO control
    output logic                    line_rst,
    output logic                    fifo0_wr_en,
    output logic [c_DATA_WIDTH-1:0] fifo0_wr_data,
    output logic                    fifo0_rd_en,
    input  logic [c_DATA_WIDTH-1:0] fifo0_rd_data,
    input  logic                    fifo0_rd_empty,
    input  logic                    fifo0_wr_full,
    output logic                    fifo1_wr_en,
    output logic [c_DATA_WIDTH-1:0] fifo1_wr_data,
    output logic                    fifo1_rd_en,
    input  logic [c_DATA_WIDTH-1:0] fifo1_rd_data,
    input  logic                    fifo1_rd_empty,
    input  logic                    fifo1_wr_full,
    // window taps
    output logic                    tap_valid,
    output logic [c_DATA_WIDTH-1:0] tap_row0,
    output logic [c_DATA_WIDTH-1:0] tap_row1,
    output logic [c_DATA_WIDTH-1:0] tap_row2,
    output logic [c_COL_WIDTH-1:0]  tap_col,
    output logic [c_ROW_WIDTH-1:0]  tap_row,
    output logic                    tap_eof,
    // status
    output logic                    frame_err,
    output logic                    fifo_err
);

    localparam logic [c_COL_WIDTH-1:0] LAST_COL = c_COL_WIDTH'(c_IMG_WIDTH - 1);
    localparam logic [c_ROW_WIDTH-1:0] LAST_ROW = c_ROW_WIDTH'(c_IMG_HEIGHT - 1);
    localparam logic [c_ROW_WIDTH-1:0] ROW_TWO  = c_ROW_WIDTH'(2);
    // FLUSH: cycle index 0 lets the pipelined FIFO1 write finish, 1..2 clear the FIFOs
    localparam logic [1:0]             FLUSH_LAST = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ROW0,
        ST_ROW1,
        ST_STEADY,
        ST_FLUSH
    } state_t;

    state_t                  state_reg, state_next;
    logic [1:0]              flush_cnt_reg, flush_cnt_next;
    logic [c_COL_WIDTH-1:0]  col_reg, col_next;
    logic [c_ROW_WIDTH-1:0]  row_reg, row_next;

    // stage-1 pipeline: what was accepted in the previous cycle
    logic                    acc_d_reg;
    logic                    r_ge1_d_reg;
    logic                    r_ge2_d_reg;
    logic                    eof_d_reg;
    logic [c_DATA_WIDTH-1:0] pix_d_reg;
    logic [c_COL_WIDTH-1:0]  col_d_reg;
    logic [c_ROW_WIDTH-1:0]  row_d_reg;

    // stage-2: tap output registers
    logic                    tap_valid_reg;
    logic [c_DATA_WIDTH-1:0] tap_row0_reg;
    logic [c_DATA_WIDTH-1:0] tap_row1_reg;
    logic [c_DATA_WIDTH-1:0] tap_row2_reg;
    logic [c_COL_WIDTH-1:0]  tap_col_reg;
    logic [c_ROW_WIDTH-1:0]  tap_row_reg;
    logic                    tap_eof_reg;

    logic in_frame;
    logic accept;
    logic sof_abort;
    logic last_col;
    logic last_pix;
    logic r_ge1;
    logic r_ge2;

    // per-FIFO strobe/flag vectors used to build fifo_err
    logic [1:0] rd_en_vec;
    logic [1:0] rd_empty_vec;
    logic [1:0] wr_en_vec;
    logic [1:0] wr_full_vec;
    logic [1:0] fifo_err_vec;

    // ------------------------------------------------------------------
    // Acceptance and position decode
    // ------------------------------------------------------------------
    assign in_frame  = (state_reg == ST_ROW0) || (state_reg == ST_ROW1) ||
                       (state_reg == ST_STEADY);
    assign accept    = pix_valid && (((state_reg == ST_IDLE) && pix_sof) ||
                                     (in_frame && !pix_sof));
    // a new sof while a frame is in progress abandons the partial frame
    assign sof_abort = pix_valid && in_frame && pix_sof;
    assign last_col  = (col_reg == LAST_COL);
    assign last_pix  = last_col && (row_reg == LAST_ROW);
    assign r_ge1     = (row_reg != '0);
    assign r_ge2     = (row_reg >= ROW_TWO);

    // ------------------------------------------------------------------
    // FSM and raster counters
    // ------------------------------------------------------------------
    // State register and position counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            flush_cnt_reg <= '0;
            col_reg       <= '0;
            row_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            flush_cnt_reg <= flush_cnt_next;
            col_reg       <= col_next;
            row_reg       <= row_next;
        end
    end

    // Next-state, flush sequencing and counter advance
    always_comb begin
        state_next     = state_reg;
        flush_cnt_next = flush_cnt_reg;
        col_next       = col_reg;
        row_next       = row_reg;

        if (accept) begin
            if (last_col) begin
                col_next = '0;
                row_next = row_reg + 1'b1;
            end else begin
                col_next = col_reg + 1'b1;
            end
        end

        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    state_next = ST_ROW0;
                end
            end
            ST_ROW0: begin
                if (accept && last_col) begin
                    state_next = ST_ROW1;
                end
            end
            ST_ROW1: begin
                if (accept && last_col) begin
                    state_next = ST_STEADY;
                end
            end
            ST_STEADY: begin
                if (accept && last_pix) begin
                    state_next     = ST_FLUSH;
                    flush_cnt_next = '0;
                    col_next       = '0;
                    row_next       = '0;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_reg == FLUSH_LAST) begin
                    state_next     = ST_IDLE;
                    flush_cnt_next = '0;
                end else begin
                    flush_cnt_next = flush_cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next     = ST_IDLE;
                flush_cnt_next = '0;
                col_next       = '0;
                row_next       = '0;
            end
        endcase

        // abandoned frame: counters restart so the next sof begins at (0,0)
        if (sof_abort) begin
            state_next     = ST_FLUSH;
            flush_cnt_next = '0;
            col_next       = '0;
            row_next       = '0;
        end
    end

    // ------------------------------------------------------------------
    // Accept-cycle FIFO strobes (combinational)
    // ------------------------------------------------------------------
    assign fifo0_wr_en   = accept;
    assign fifo0_wr_data = pix_data;
    assign fifo0_rd_en   = accept && r_ge1;
    assign fifo1_rd_en   = accept && r_ge2;

    // FIFO0 read data arrives one cycle after the read and is forwarded
    // into FIFO1 as the row r-2 delay line
    assign fifo1_wr_en   = acc_d_reg && r_ge1_d_reg;
    assign fifo1_wr_data = fifo0_rd_data;

    // ------------------------------------------------------------------
    // Pipeline stage 1: hold the accepted pixel while FIFO reads return
    // ------------------------------------------------------------------
    // Delay the pixel and its position by one cycle to align with FIFO read data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_d_reg   <= 1'b0;
            r_ge1_d_reg <= 1'b0;
            r_ge2_d_reg <= 1'b0;
            eof_d_reg   <= 1'b0;
            pix_d_reg   <= '0;
            col_d_reg   <= '0;
            row_d_reg   <= '0;
        end else begin
            acc_d_reg   <= accept;
            r_ge1_d_reg <= r_ge1;
            r_ge2_d_reg <= r_ge2;
            eof_d_reg   <= accept && last_pix;
            if (accept) begin
                pix_d_reg <= pix_data;
                col_d_reg <= col_reg;
                row_d_reg <= row_reg;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pipeline stage 2: capture the three row taps
    // ------------------------------------------------------------------
    // Register the column-aligned taps; rows above the frame read as zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tap_valid_reg <= 1'b0;
            tap_row0_reg  <= '0;
            tap_row1_reg  <= '0;
            tap_row2_reg  <= '0;
            tap_col_reg   <= '0;
            tap_row_reg   <= '0;
            tap_eof_reg   <= 1'b0;
        end else begin
            tap_valid_reg <= acc_d_reg;
            tap_eof_reg   <= eof_d_reg;
            if (acc_d_reg) begin
                tap_row0_reg <= pix_d_reg;
                tap_row1_reg <= r_ge1_d_reg ? fifo0_rd_data : '0;
                tap_row2_reg <= r_ge2_d_reg ? fifo1_rd_data : '0;
                tap_col_reg  <= col_d_reg;
                tap_row_reg  <= row_d_reg;
            end
        end
    end

    assign tap_valid = tap_valid_reg;
    assign tap_row0  = tap_row0_reg;
    assign tap_row1  = tap_row1_reg;
    assign tap_row2  = tap_row2_reg;
    assign tap_col   = tap_col_reg;
    assign tap_row   = tap_row_reg;
    assign tap_eof   = tap_eof_reg;

    // ------------------------------------------------------------------
    // Flush control and status
    // ------------------------------------------------------------------
    assign pix_ready = (state_reg != ST_FLUSH);
    assign line_rst  = (state_reg == ST_FLUSH) && (flush_cnt_reg != '0);

    // every pixel strobe that is not accepted is a protocol violation
    assign frame_err = pix_valid && !accept;

    assign rd_en_vec    = {fifo1_rd_en, fifo0_rd_en};
    assign rd_empty_vec = {fifo1_rd_empty, fifo0_rd_empty};
    assign wr_en_vec    = {fifo1_wr_en, fifo0_wr_en};
    assign wr_full_vec  = {fifo1_wr_full, fifo0_wr_full};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fifo_err
            // strobes are still issued; the error only reports the misuse
            assign fifo_err_vec[gi] = (rd_en_vec[gi] && rd_empty_vec[gi]) ||
                                      (wr_en_vec[gi] && wr_full_vec[gi]);
        end
    endgenerate

    assign fifo_err = |fifo_err_vec;

endmodule

// File: tb/tb_matrix_line_sched.sv
// Directed bench for matrix_line_sched with a 4x3 image and behavioural
// models of the two line FIFOs (synchronous, read latency 1).
module tb_matrix_line_sched;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int DW = 8;
    localparam int CW = 2;
    localparam int RW = 2;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pix_sof = 1'b0;
    logic          pix_valid = 1'b0;
    logic [DW-1:0] pix_data = '0;
    logic          pix_ready;
    logic          line_rst;
    logic          fifo0_wr_en, fifo0_rd_en, fifo1_wr_en, fifo1_rd_en;
    logic [DW-1:0] fifo0_wr_data, fifo1_wr_data;
    logic [DW-1:0] fifo0_rd_data, fifo1_rd_data;
    logic          fifo0_rd_empty, fifo1_rd_empty, fifo0_wr_full, fifo1_wr_full;
    logic          tap_valid;
    logic [DW-1:0] tap_row0, tap_row1, tap_row2;
    logic [CW-1:0] tap_col;
    logic [RW-1:0] tap_row;
    logic          tap_eof;
    logic          frame_err;
    logic          fifo_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    matrix_line_sched #(
        .c_DATA_WIDTH(DW), .c_IMG_WIDTH(W), .c_IMG_HEIGHT(H),
        .c_COL_WIDTH(CW), .c_ROW_WIDTH(RW)
    ) dut (
        .clk(clk), .rst(rst),
        .pix_sof(pix_sof), .pix_valid(pix_valid), .pix_data(pix_data),
        .pix_ready(pix_ready), .line_rst(line_rst),
        .fifo0_wr_en(fifo0_wr_en), .fifo0_wr_data(fifo0_wr_data),
        .fifo0_rd_en(fifo0_rd_en), .fifo0_rd_data(fifo0_rd_data),
        .fifo0_rd_empty(fifo0_rd_empty), .fifo0_wr_full(fifo0_wr_full),
        .fifo1_wr_en(fifo1_wr_en), .fifo1_wr_data(fifo1_wr_data),
        .fifo1_rd_en(fifo1_rd_en), .fifo1_rd_data(fifo1_rd_data),
        .fifo1_rd_empty(fifo1_rd_empty), .fifo1_wr_full(fifo1_wr_full),
        .tap_valid(tap_valid), .tap_row0(tap_row0), .tap_row1(tap_row1),
        .tap_row2(tap_row2), .tap_col(tap_col), .tap_row(tap_row),
        .tap_eof(tap_eof), .frame_err(frame_err), .fifo_err(fifo_err)
    );

    // ---------------- line FIFO models ----------------
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    int cnt0 = 0;
    int cnt1 = 0;
    logic force0 = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst || line_rst) begin
            q0.delete();
            q1.delete();
            fifo0_rd_data <= '0;
            fifo1_rd_data <= '0;
        end else begin
            if (fifo0_rd_en && q0.size() > 0) fifo0_rd_data <= q0.pop_front();
            if (fifo1_rd_en && q1.size() > 0) fifo1_rd_data <= q1.pop_front();
            if (fifo0_wr_en) q0.push_back(fifo0_wr_data);
            if (fifo1_wr_en) q1.push_back(fifo1_wr_data);
        end
        cnt0 <= q0.size();
        cnt1 <= q1.size();
    end

    assign fifo0_rd_empty = (cnt0 == 0) || force0;
    assign fifo1_rd_empty = (cnt1 == 0);
    assign fifo0_wr_full  = (cnt0 >= DEPTH);
    assign fifo1_wr_full  = (cnt1 >= DEPTH);

    // ---------------- output monitor ----------------
    typedef struct {
        logic [DW-1:0] r0;
        logic [DW-1:0] r1;
        logic [DW-1:0] r2;
        int            col;
        int            row;
        logic          eof;
        int            cyc;
    } tap_t;

    tap_t taps[$];
    int n_line_rst = 0, n_frame_err = 0, n_fifo_err = 0, n_eof = 0, n_notready = 0;
    int n_f0wr = 0, n_f0rd = 0, n_f1wr = 0, n_f1rd = 0;
    int lr_start = -1;
    logic lr_prev = 1'b0;

    always @(negedge clk) begin
        if (tap_valid) begin
            taps.push_back('{tap_row0, tap_row1, tap_row2, int'(tap_col),
                             int'(tap_row), tap_eof, cyc});
            $display("tap  cyc=%0d (r=%0d,c=%0d) row0=%02h row1=%02h row2=%02h eof=%0b",
                     cyc, tap_row, tap_col, tap_row0, tap_row1, tap_row2, tap_eof);
        end
        if (line_rst)    n_line_rst  <= n_line_rst + 1;
        if (frame_err)   n_frame_err <= n_frame_err + 1;
        if (fifo_err)    n_fifo_err  <= n_fifo_err + 1;
        if (tap_valid && tap_eof) n_eof <= n_eof + 1;
        if (!pix_ready)  n_notready  <= n_notready + 1;
        if (fifo0_wr_en) n_f0wr <= n_f0wr + 1;
        if (fifo0_rd_en) n_f0rd <= n_f0rd + 1;
        if (fifo1_wr_en) n_f1wr <= n_f1wr + 1;
        if (fifo1_rd_en) n_f1rd <= n_f1rd + 1;
        if (line_rst && !lr_prev) lr_start <= cyc;
        lr_prev <= line_rst;
    end

    // ---------------- stimulus helpers ----------------
    int exp_r[$];
    int exp_c[$];
    int exp_cyc[$];

    function automatic logic [3*DW-1:0] exp_vals(input int r, input int c);
        logic [DW-1:0] a, b, d;
        a = DW'(16 * r + c);
        b = (r >= 1) ? DW'(16 * (r - 1) + c) : '0;
        d = (r >= 2) ? DW'(16 * (r - 2) + c) : '0;
        return {a, b, d};
    endfunction

    task automatic drive(input logic v, input logic s, input logic [DW-1:0] d);
        @(posedge clk);
        #1;
        pix_valid = v;
        pix_sof   = s;
        pix_data  = d;
    endtask

    // One frame of 16r+c pixels; gap idle cycles after each pixel, an
    // optional mid-frame sof at index abort_at, and tail stray pixels.
    task automatic send_frame(input int gap, input int abort_at, input int tail);
        exp_r.delete();
        exp_c.delete();
        exp_cyc.delete();
        for (int i = 0; i < W * H; i++) begin
            int r;
            int c;
            r = i / W;
            c = i % W;
            if (i == abort_at) begin
                drive(1'b1, 1'b1, 8'hEE);
                break;
            end
            drive(1'b1, (i == 0), DW'(16 * r + c));
            exp_r.push_back(r);
            exp_c.push_back(c);
            exp_cyc.push_back(cyc);
            for (int g = 0; g < gap; g++) drive(1'b0, 1'b0, '0);
        end
        for (int t = 0; t < tail; t++) drive(1'b1, 1'b0, 8'hAA);
        for (int k = 0; k < 8; k++) drive(1'b0, 1'b0, '0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        $display("test_reset");
        #1;
        checks++;
        if ({tap_valid, line_rst, frame_err, fifo_err, tap_eof} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 00000",
                     {tap_valid, line_rst, frame_err, fifo_err, tap_eof});
        end
        checks++;
        if ({fifo0_wr_en, fifo0_rd_en, fifo1_wr_en, fifo1_rd_en} !== 4'b0) begin
            errors++;
            $display("FAIL reset_strobes: got %b want 0000",
                     {fifo0_wr_en, fifo0_rd_en, fifo1_wr_en, fifo1_rd_en});
        end
        checks++;
        if (pix_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b want 1", pix_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        // start a frame, then hit rst asynchronously mid-stream
        drive(1'b1, 1'b1, 8'h00);
        for (int i = 1; i < 6; i++) drive(1'b1, 1'b0, DW'(16 * (i / W) + (i % W)));
        #3;
        pix_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if ({tap_valid, line_rst, fifo1_wr_en, fifo0_rd_en} !== 4'b0) begin
            errors++;
            $display("FAIL async_reset_outputs: got %b want 0000",
                     {tap_valid, line_rst, fifo1_wr_en, fifo0_rd_en});
        end
        checks++;
        if ({tap_row0, tap_row1, tap_row2, tap_col, tap_row} !== '0) begin
            errors++;
            $display("FAIL async_reset_taps: got %02h %02h %02h c=%0d r=%0d want all 0",
                     tap_row0, tap_row1, tap_row2, tap_col, tap_row);
        end
        checks++;
        if (pix_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset_ready: got %b want 1", pix_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        // state must be IDLE: a non-sof pixel is rejected
        drive(1'b1, 1'b0, 8'h33);
        @(negedge clk);
        checks++;
        if ({frame_err, fifo0_wr_en} !== 2'b10) begin
            errors++;
            $display("FAIL reset_idle: frame_err/wr_en got %b want 10", {frame_err, fifo0_wr_en});
        end
        for (int k = 0; k < 4; k++) drive(1'b0, 1'b0, '0);
    endtask

    task automatic test_frame;
        int s, e0, l0, f0, fr0;
        logic [3*DW-1:0] ev;
        $display("test_frame");
        s = taps.size(); e0 = n_eof; l0 = n_line_rst; f0 = n_fifo_err; fr0 = n_frame_err;
        send_frame(0, -1, 0);
        checks++;
        if (taps.size() - s != W * H) begin
            errors++;
            $display("FAIL frame_tap_count: got %0d want %0d", taps.size() - s, W * H);
        end
        for (int i = 0; i < exp_r.size(); i++) begin
            ev = exp_vals(exp_r[i], exp_c[i]);
            checks++;
            if (s + i >= taps.size()) begin
                errors++;
                $display("FAIL frame_tap_missing: idx %0d", i);
            end else if ({taps[s+i].r0, taps[s+i].r1, taps[s+i].r2, taps[s+i].row,
                          taps[s+i].col, taps[s+i].eof, taps[s+i].cyc} !==
                         {ev, exp_r[i], exp_c[i], (exp_r[i] == H-1 && exp_c[i] == W-1),
                          exp_cyc[i] + 2}) begin
                errors++;
                $display("FAIL frame_tap %0d: got %02h %02h %02h (%0d,%0d) eof=%0b cyc=%0d want %06h (%0d,%0d) cyc=%0d",
                         i, taps[s+i].r0, taps[s+i].r1, taps[s+i].r2, taps[s+i].row,
                         taps[s+i].col, taps[s+i].eof, taps[s+i].cyc, ev,
                         exp_r[i], exp_c[i], exp_cyc[i] + 2);
            end
        end
        checks++;
        if (taps.size() > s + 9 &&
            {taps[s+9].r0, taps[s+9].r1, taps[s+9].r2} !== 24'h211101) begin
            errors++;
            $display("FAIL frame_tap_r2c1: got %02h %02h %02h want 21 11 01",
                     taps[s+9].r0, taps[s+9].r1, taps[s+9].r2);
        end
        checks++;
        if (n_eof - e0 != 1) begin
            errors++;
            $display("FAIL frame_eof_count: got %0d want 1", n_eof - e0);
        end
        checks++;
        if (n_line_rst - l0 != 2) begin
            errors++;
            $display("FAIL frame_line_rst_len: got %0d want 2", n_line_rst - l0);
        end
        checks++;
        if (lr_start != exp_cyc[exp_cyc.size()-1] + 2) begin
            errors++;
            $display("FAIL frame_line_rst_start: got %0d want %0d",
                     lr_start, exp_cyc[exp_cyc.size()-1] + 2);
        end
        checks++;
        if (n_fifo_err != f0 || n_frame_err != fr0) begin
            errors++;
            $display("FAIL frame_no_errors: fifo_err %0d frame_err %0d want 0 0",
                     n_fifo_err - f0, n_frame_err - fr0);
        end
        checks++;
        if (cnt0 != 0 || cnt1 != 0) begin
            errors++;
            $display("FAIL frame_fifos_empty: got %0d %0d want 0 0", cnt0, cnt1);
        end
    endtask

    task automatic test_gap;
        int s, l0;
        logic [3*DW-1:0] ev;
        $display("test_gap");
        s = taps.size(); l0 = n_line_rst;
        send_frame(1, -1, 0);
        checks++;
        if (taps.size() - s != W * H) begin
            errors++;
            $display("FAIL gap_tap_count: got %0d want %0d", taps.size() - s, W * H);
        end
        for (int i = 0; i < exp_r.size(); i++) begin
            ev = exp_vals(exp_r[i], exp_c[i]);
            checks++;
            if (s + i >= taps.size()) begin
                errors++;
                $display("FAIL gap_tap_missing: idx %0d", i);
            end else if ({taps[s+i].r0, taps[s+i].r1, taps[s+i].r2, taps[s+i].cyc} !==
                         {ev, exp_cyc[i] + 2} ||
                         (i > 0 && taps[s+i].cyc - taps[s+i-1].cyc != 2)) begin
                errors++;
                $display("FAIL gap_tap %0d: got %02h %02h %02h cyc=%0d want %06h cyc=%0d spacing 2",
                         i, taps[s+i].r0, taps[s+i].r1, taps[s+i].r2, taps[s+i].cyc,
                         ev, exp_cyc[i] + 2);
            end
        end
        checks++;
        if (n_line_rst - l0 != 2) begin
            errors++;
            $display("FAIL gap_line_rst_len: got %0d want 2", n_line_rst - l0);
        end
    endtask

    task automatic test_sof_abort;
        int s, e0, l0, fr0, nr0;
        logic [3*DW-1:0] ev;
        $display("test_sof_abort");
        s = taps.size(); e0 = n_eof; l0 = n_line_rst; fr0 = n_frame_err; nr0 = n_notready;
        send_frame(0, 6, 0);
        checks++;
        if (taps.size() - s != 6 || n_eof != e0) begin
            errors++;
            $display("FAIL abort_taps: got %0d taps eof=%0d want 6 taps eof=0",
                     taps.size() - s, n_eof - e0);
        end
        checks++;
        if (n_frame_err - fr0 != 1) begin
            errors++;
            $display("FAIL abort_frame_err: got %0d want 1", n_frame_err - fr0);
        end
        checks++;
        if (n_line_rst - l0 != 2 || n_notready - nr0 != 3) begin
            errors++;
            $display("FAIL abort_flush: line_rst %0d not_ready %0d want 2 3",
                     n_line_rst - l0, n_notready - nr0);
        end
        // the next frame must start cleanly from a fresh sof
        s = taps.size(); e0 = n_eof;
        send_frame(0, -1, 0);
        for (int i = 0; i < exp_r.size(); i++) begin
            ev = exp_vals(exp_r[i], exp_c[i]);
            checks++;
            if (s + i >= taps.size()) begin
                errors++;
                $display("FAIL abort_next_missing: idx %0d", i);
            end else if ({taps[s+i].r0, taps[s+i].r1, taps[s+i].r2} !== ev) begin
                errors++;
                $display("FAIL abort_next_tap %0d: got %02h %02h %02h want %06h",
                         i, taps[s+i].r0, taps[s+i].r1, taps[s+i].r2, ev);
            end
        end
        checks++;
        if (n_eof - e0 != 1) begin
            errors++;
            $display("FAIL abort_next_eof: got %0d want 1", n_eof - e0);
        end
    endtask

    task automatic test_drop;
        int fr0, w0, r0, w1, r1, s;
        $display("test_drop");
        fr0 = n_frame_err; w0 = n_f0wr; r0 = n_f0rd; w1 = n_f1wr; r1 = n_f1rd;
        drive(1'b1, 1'b0, 8'h55);
        for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, '0);
        checks++;
        if (n_frame_err - fr0 != 1 ||
            {n_f0wr - w0, n_f0rd - r0, n_f1wr - w1, n_f1rd - r1} !== '0) begin
            errors++;
            $display("FAIL drop_idle: frame_err %0d strobes %0d %0d %0d %0d want 1 0 0 0 0",
                     n_frame_err - fr0, n_f0wr - w0, n_f0rd - r0, n_f1wr - w1, n_f1rd - r1);
        end
        fr0 = n_frame_err; w0 = n_f0wr; r0 = n_f0rd; w1 = n_f1wr; r1 = n_f1rd;
        s = taps.size();
        send_frame(0, -1, 2);
        checks++;
        if (n_frame_err - fr0 != 2) begin
            errors++;
            $display("FAIL drop_flush_err: got %0d want 2", n_frame_err - fr0);
        end
        checks++;
        if (n_f0wr - w0 != 12 || n_f0rd - r0 != 8 || n_f1wr - w1 != 8 ||
            n_f1rd - r1 != 4 || taps.size() - s != 12) begin
            errors++;
            $display("FAIL drop_flush_strobes: got f0wr %0d f0rd %0d f1wr %0d f1rd %0d taps %0d want 12 8 8 4 12",
                     n_f0wr - w0, n_f0rd - r0, n_f1wr - w1, n_f1rd - r1, taps.size() - s);
        end
    endtask

    task automatic test_fifo_err;
        int f0;
        $display("test_fifo_err");
        f0 = n_fifo_err;
        for (int i = 0; i < W; i++) drive(1'b1, (i == 0), DW'(i));
        @(negedge clk);
        checks++;
        if (fifo_err !== 1'b0) begin
            errors++;
            $display("FAIL fifo_err_idle_row0: got %b want 0", fifo_err);
        end
        drive(1'b1, 1'b0, 8'h10);
        force0 = 1'b1;
        @(negedge clk);
        checks++;
        if ({fifo_err, fifo0_rd_en} !== 2'b11) begin
            errors++;
            $display("FAIL fifo_err_pulse: fifo_err/rd_en got %b want 11", {fifo_err, fifo0_rd_en});
        end
        for (int i = W + 1; i < W * H; i++) begin
            drive(1'b1, 1'b0, DW'(16 * (i / W) + (i % W)));
            force0 = 1'b0;
        end
        for (int k = 0; k < 8; k++) drive(1'b0, 1'b0, '0);
        checks++;
        if (n_fifo_err - f0 != 1) begin
            errors++;
            $display("FAIL fifo_err_count: got %0d want 1", n_fifo_err - f0);
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_gap();
        test_sof_abort();
        test_drop();
        test_fifo_err();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
